_button_event_scheduler: RTL
============================

// Module: _button_event_scheduler
// PURPOSE
//  Debounces N_CH push-button inputs and classifies each into PRESS, RELEASE and LONG events.
//  All channels share one tick prescaler and one event output, arbitrated round-robin
//  with a valid/ready handshake.
//  Sits between raw iCEstick/PMOD buttons and application logic.
// PARAMETERS
//  N_CH          4            number of button channels (>=2)
//  CLK_ITER_MAX  1200000-1    prescaler terminal count; tick period = CLK_ITER_MAX+1 clk (10 ms @120 MHz)
//  STABLE_TICKS  2            consecutive equal ticks to accept a level change (>=2)
//  LONG_TICKS    100          ticks held after PRESS before LONG fires (>STABLE_TICKS)
// PORTS
//  ref_clk    in   1                 system clock, 120 MHz
//  rstI_n     in   1                 reset: synchronous, active-low
//  sigI       in   N_CH              raw asynchronous button levels, 1 = pressed
//  ev_valid   out  1                 event present on ev_chan/ev_type
//  ev_ready   in   1                 consumer accepts when ev_valid & ev_ready at posedge
//  ev_chan    out  $clog2(N_CH)      channel of current event
//  ev_type    out  2                 2'b01 PRESS, 2'b10 RELEASE, 2'b11 LONG (2'b00 never driven valid)
//  level      out  N_CH              debounced level per channel
//  overflow   out  N_CH              sticky: event dropped on channel
//  ovf_clr    in   1                 clears all overflow bits
// BEHAVIOUR
//  Reset (rstI_n=0 at posedge): ev_valid/ev_chan/ev_type/level/overflow = 0.
//   FSMs -> RELEASED, pending slots empty, prescaler = 0, RR pointer = N_CH-1 (ch0 first).
//   A mid-operation reset discards pending/output events and emits no RELEASE.
//  Sync: 2-FF synchronizer per sigI bit (reset 0); FSMs see only the synced level s.
//  Prescaler: counts 0..CLK_ITER_MAX, then wraps to 0.
//   tick = 1 for exactly the cycle where count == CLK_ITER_MAX.
//   CLK_ITER_MAX = 0 gives tick every cycle.
//  Per-channel FSM advances only on tick. Counters: cnt (stability), hold (saturates at LONG_TICKS).
//  Flag long_sent.
//   RELEASED:    s=1 -> PRESS_CHK, cnt=1.
//   PRESS_CHK:   s=0 -> RELEASED.
//                s=1: cnt+1==STABLE_TICKS -> PRESSED, level=1, post PRESS, hold=0, long_sent=0;
//                else cnt++.
//   PRESSED:     s=1: hold++; hold+1==LONG_TICKS & !long_sent -> post LONG, long_sent=1.
//                s=0 -> RELEASE_CHK, cnt=1.
//   RELEASE_CHK: s=1 -> PRESSED (hold/long_sent kept, so no second LONG).
//                s=0: cnt+1==STABLE_TICKS -> RELEASED, level=0, post RELEASE; else cnt++.
//  Pending slot: 1 deep per channel; a post on tick cycle T sets the slot at T+1.
//   Post into an occupied slot drops the new event and sets overflow[ch].
//   A slot granted in the same cycle is not occupied, so the event is stored and no overflow is set.
//   overflow set has priority over ovf_clr in the same cycle.
//  Output register is loadable when !ev_valid | ev_ready.
//   Arbiter picks the first pending channel after the RR pointer (wrapping).
//   It loads ev_*, clears that slot and sets the pointer = granted channel.
//   ev_valid/ev_chan/ev_type are held stable while ev_valid & !ev_ready.
//  Latency: post at T -> ev_valid at T+2 minimum. With ev_ready=1 throughput is 1 event/clk.
// STRUCTURE
//  Package _button_event_pkg:
//   - EV_PRESS/EV_RELEASE/EV_LONG localparams.
//   - FSM state encoding (RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK).
//  Sub-module _button_channel_fsm (synchronizer + FSM + counters + post strobe/type): one per channel, via generate.
//  Prescaler, pending slots, RR arbiter and output register stay inline in top.
//   Do not reuse _clock_divider: it uses an async active-high reset.
// TESTING (bench params: CLK_ITER_MAX=3, STABLE_TICKS=3, LONG_TICKS=8, N_CH=4, ev_ready=1 unless stated)
//  1 Hold rstI_n=0 with sigI=4'hF for 10 clk.
//    -> all outputs 0. After release, PRESS on ch0..3 appears in order 0,1,2,3 on consecutive clk.
//  2 ch1 bounce 1,0,1 across 3 ticks, then stable 1 for 3 ticks.
//    -> exactly one PRESS ch1; level[1] rises on the 3rd stable tick (+1 clk); no event during the bounce.
//  3 ch2 held 1 for 12 ticks, then 0.
//    -> PRESS, then one LONG 8 ticks later, then RELEASE 3 ticks after the fall.
//    -> a single 1-tick low glitch mid-hold produces no second LONG.
//  4 ev_ready=0; ch0 posts PRESS, then RELEASE.
//    -> ev_valid held with ch0/PRESS stable; RELEASE sits in slot; a third post sets overflow[0].
//    -> ovf_clr clears it.
//  5 ch0 and ch3 post on the same tick, ev_ready=1.
//    -> grant order follows the RR pointer (ch3 first if the last grant was ch1), back-to-back cycles.
//  6 Assert rstI_n=0 while ch2 is PRESSED with an event pending.
//    -> level/ev_valid 0 next clk; no RELEASE emitted after reset.

Source files
------------

// File: rtl/_button_event_pkg.sv
// Shared definitions for the button event scheduler.
// Contents:
//   EV_NONE/EV_PRESS/EV_RELEASE/EV_LONG  event type codes carried on ev_type
//   btn_state_e                          per-channel debounce/classification state
package _button_event_pkg;

    localparam logic [1:0] EV_NONE    = 2'b00;
    localparam logic [1:0] EV_PRESS   = 2'b01;
    localparam logic [1:0] EV_RELEASE = 2'b10;
    localparam logic [1:0] EV_LONG    = 2'b11;

    typedef enum logic [1:0] {
        ST_RELEASED    = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } btn_state_e;

endpackage

// File: rtl/_button_channel_fsm.sv
// One button channel: 2-FF synchronizer, debounce FSM and event classifier.
// Ports:
//   ref_clk    in   system clock
//   rstI_n     in   synchronous active-low reset
//   tick       in   prescaler strobe; the FSM only advances on cycles where it is 1
//   sig_raw    in   raw asynchronous button level, 1 = pressed
//   level      out  debounced level (registered)
//   post       out  one-cycle strobe on the tick cycle an event is produced
//   post_type  out  type of the posted event (EV_NONE when post is 0)
module _button_channel_fsm
    import _button_event_pkg::*;
#(
    parameter int STABLE_TICKS = 2,
    parameter int LONG_TICKS   = 100
) (
    input  logic       ref_clk,
    input  logic       rstI_n,
    input  logic       tick,
    input  logic       sig_raw,
    output logic       level,
    output logic       post,
    output logic [1:0] post_type
);

    localparam int CNT_W  = $clog2(STABLE_TICKS + 1);
    localparam int HOLD_W = $clog2(LONG_TICKS + 1);

    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    // cnt+1 == STABLE_TICKS is written as cnt == STABLE_TICKS-1 to keep widths exact
    localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(LONG_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX    = HOLD_W'(LONG_TICKS);

    logic              sync1_r;
    logic              sync2_r;
    btn_state_e        state_r;
    btn_state_e        state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_s;
    logic [HOLD_W-1:0] hold_r;
    logic [HOLD_W-1:0] hold_s;
    logic              long_sent_r;
    logic              long_sent_s;
    logic              level_r;
    logic              level_s;
    logic              post_s;
    logic [1:0]        post_type_s;

    // Two-flop synchronizer bringing the raw button level into the clock domain
    always_ff @(posedge ref_clk) begin
        if (!rstI_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= sig_raw;
            sync2_r <= sync1_r;
        end
    end

    // FSM state, counters and debounced level register
    always_ff @(posedge ref_clk) begin
        if (!rstI_n) begin
            state_r     <= ST_RELEASED;
            cnt_r       <= '0;
            hold_r      <= '0;
            long_sent_r <= 1'b0;
            level_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            hold_r      <= hold_s;
            long_sent_r <= long_sent_s;
            level_r     <= level_s;
        end
    end

    // Next-state, counter updates and event post decode; everything holds off-tick
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        hold_s      = hold_r;
        long_sent_s = long_sent_r;
        level_s     = level_r;
        post_s      = 1'b0;
        post_type_s = EV_NONE;
        if (tick) begin
            case (state_r)
                ST_RELEASED: begin
                    if (sync2_r) begin
                        state_s = ST_PRESS_CHK;
                        cnt_s   = CNT_ONE;
                    end else begin
                        state_s = ST_RELEASED;
                    end
                end
                ST_PRESS_CHK: begin
                    if (!sync2_r) begin
                        state_s = ST_RELEASED;
                    end else if (cnt_r == STABLE_LAST) begin
                        state_s     = ST_PRESSED;
                        level_s     = 1'b1;
                        post_s      = 1'b1;
                        post_type_s = EV_PRESS;
                        hold_s      = '0;
                        long_sent_s = 1'b0;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_PRESSED: begin
                    if (sync2_r) begin
                        if (hold_r != HOLD_MAX) begin
                            hold_s = hold_r + HOLD_ONE;
                        end else begin
                            hold_s = hold_r;
                        end
                        if ((hold_r == HOLD_LAST) && !long_sent_r) begin
                            post_s      = 1'b1;
                            post_type_s = EV_LONG;
                            long_sent_s = 1'b1;
                        end else begin
                            long_sent_s = long_sent_r;
                        end
                    end else begin
                        state_s = ST_RELEASE_CHK;
                        cnt_s   = CNT_ONE;
                    end
                end
                ST_RELEASE_CHK: begin
                    // Returning to PRESSED keeps hold/long_sent so a glitch cannot re-fire LONG
                    if (sync2_r) begin
                        state_s = ST_PRESSED;
                    end else if (cnt_r == STABLE_LAST) begin
                        state_s     = ST_RELEASED;
                        level_s     = 1'b0;
                        post_s      = 1'b1;
                        post_type_s = EV_RELEASE;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_s = ST_RELEASED;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    assign level     = level_r;
    assign post      = post_s;
    assign post_type = post_type_s;

endmodule

// File: rtl/_button_event_scheduler.sv
// Debounces N_CH push buttons, classifies PRESS/RELEASE/LONG events and
// serialises them onto one valid/ready event port with round-robin arbitration.
// Ports:
//   ref_clk    in   system clock
//   rstI_n     in   synchronous active-low reset
//   sigI       in   raw button levels, 1 = pressed
//   ev_valid   out  event present on ev_chan/ev_type
//   ev_ready   in   consumer accepts when ev_valid & ev_ready at posedge
//   ev_chan    out  channel of current event
//   ev_type    out  01 PRESS, 10 RELEASE, 11 LONG
//   level      out  debounced level per channel
//   overflow   out  sticky per-channel flag: an event was dropped
//   ovf_clr    in   clears all overflow bits
module _button_event_scheduler
    import _button_event_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int CLK_ITER_MAX = 1200000 - 1,
    parameter int STABLE_TICKS = 2,
    parameter int LONG_TICKS   = 100
) (
    input  logic                    ref_clk,
    input  logic                    rstI_n,
    input  logic [N_CH-1:0]         sigI,
    output logic                    ev_valid,
    input  logic                    ev_ready,
    output logic [$clog2(N_CH)-1:0] ev_chan,
    output logic [1:0]              ev_type,
    output logic [N_CH-1:0]         level,
    output logic [N_CH-1:0]         overflow,
    input  logic                    ovf_clr
);

    localparam int CH_W    = $clog2(N_CH);
    localparam int PRESC_W = (CLK_ITER_MAX > 0) ? $clog2(CLK_ITER_MAX + 1) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_ITER_MAX);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
    localparam logic [CH_W-1:0]    PTR_INIT   = CH_W'(N_CH - 1);

    logic [PRESC_W-1:0] presc_r;
    logic               tick_s;
    logic [N_CH-1:0]    level_s;
    logic [N_CH-1:0]    post_s;
    logic [1:0]         post_type_s [N_CH];
    logic [N_CH-1:0]    slot_vld_r;
    logic [1:0]         slot_type_r [N_CH];
    logic [N_CH-1:0]    overflow_r;
    logic [CH_W-1:0]    rr_ptr_r;
    logic               ev_valid_r;
    logic [CH_W-1:0]    ev_chan_r;
    logic [1:0]         ev_type_r;
    logic               load_s;
    logic               grant_vld_s;
    logic [CH_W-1:0]    grant_ch_s;
    logic [N_CH-1:0]    grant_oh_s;
    logic [N_CH-1:0]    ovf_set_s;
    logic [N_CH-1:0]    store_s;

    // Shared tick prescaler: counts 0..CLK_ITER_MAX and wraps
    always_ff @(posedge ref_clk) begin
        if (!rstI_n) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PRESC_ONE;
        end
    end

    assign tick_s = (presc_r == PRESC_LAST);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        _button_channel_fsm #(
            .STABLE_TICKS (STABLE_TICKS),
            .LONG_TICKS   (LONG_TICKS)
        ) u_ch (
            .ref_clk   (ref_clk),
            .rstI_n    (rstI_n),
            .tick      (tick_s),
            .sig_raw   (sigI[g]),
            .level     (level_s[g]),
            .post      (post_s[g]),
            .post_type (post_type_s[g])
        );
    end

    assign load_s = !ev_valid_r || ev_ready;

    // Round-robin pick: first pending slot after the pointer, wrapping
    always_comb begin
        logic [CH_W-1:0] cand;
        grant_vld_s = 1'b0;
        grant_ch_s  = '0;
        grant_oh_s  = '0;
        cand        = '0;
        for (int k = 1; k <= N_CH; k++) begin
            cand = CH_W'((int'(rr_ptr_r) + k) % N_CH);
            if (slot_vld_r[cand] && !grant_vld_s) begin
                grant_vld_s = 1'b1;
                grant_ch_s  = cand;
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
        if (load_s && grant_vld_s) begin
            grant_oh_s[grant_ch_s] = 1'b1;
        end else begin
            grant_oh_s = '0;
        end
    end

    // A slot being granted this cycle counts as free for an incoming post
    assign ovf_set_s = post_s & slot_vld_r & ~grant_oh_s;
    assign store_s   = post_s & ~ovf_set_s;

    // One-deep pending slot per channel
    always_ff @(posedge ref_clk) begin
        if (!rstI_n) begin
            slot_vld_r <= '0;
            for (int c = 0; c < N_CH; c++) begin
                slot_type_r[c] <= EV_NONE;
            end
        end else begin
            slot_vld_r <= (slot_vld_r & ~grant_oh_s) | store_s;
            for (int c = 0; c < N_CH; c++) begin
                if (store_s[c]) begin
                    slot_type_r[c] <= post_type_s[c];
                end else begin
                    slot_type_r[c] <= slot_type_r[c];
                end
            end
        end
    end

    // Sticky overflow flags; a new drop wins over a simultaneous clear
    always_ff @(posedge ref_clk) begin
        if (!rstI_n) begin
            overflow_r <= '0;
        end else begin
            overflow_r <= ovf_set_s | (overflow_r & ~{N_CH{ovf_clr}});
        end
    end

    // Output event register and round-robin pointer
    always_ff @(posedge ref_clk) begin
        if (!rstI_n) begin
            ev_valid_r <= 1'b0;
            ev_chan_r  <= '0;
            ev_type_r  <= EV_NONE;
            rr_ptr_r   <= PTR_INIT;
        end else if (load_s) begin
            if (grant_vld_s) begin
                ev_valid_r <= 1'b1;
                ev_chan_r  <= grant_ch_s;
                ev_type_r  <= slot_type_r[grant_ch_s];
                rr_ptr_r   <= grant_ch_s;
            end else begin
                ev_valid_r <= 1'b0;
            end
        end else begin
            ev_valid_r <= ev_valid_r;
        end
    end

    assign ev_valid = ev_valid_r;
    assign ev_chan  = ev_chan_r;
    assign ev_type  = ev_type_r;
    assign level    = level_s;
    assign overflow = overflow_r;

endmodule
